// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - shared Y86-64 register file constants and register indices
package y86_pkg;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 4;
    localparam int NREGS  = 15;
    localparam int CNT_W  = 2;

    localparam logic [3:0] RNONE  = 4'hF;
    localparam int         SP_IDX = 4;

    localparam logic [3:0] RAX = 4'd0;
    localparam logic [3:0] RCX = 4'd1;
    localparam logic [3:0] RDX = 4'd2;
    localparam logic [3:0] RBX = 4'd3;
    localparam logic [3:0] RSP = 4'd4;
    localparam logic [3:0] RBP = 4'd5;
    localparam logic [3:0] RSI = 4'd6;
    localparam logic [3:0] RDI = 4'd7;
    localparam logic [3:0] R8  = 4'd8;
    localparam logic [3:0] R9  = 4'd9;
    localparam logic [3:0] R10 = 4'd10;
    localparam logic [3:0] R11 = 4'd11;
    localparam logic [3:0] R12 = 4'd12;
    localparam logic [3:0] R13 = 4'd13;
    localparam logic [3:0] R14 = 4'd14;

endpackage

// File: rtl/pipe_sb_counter.sv
// rtl/pipe_sb_counter.sv - saturating/clamped pending-write counter for one register
module pipe_sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       inc,
    input  logic [1:0]       dec,
    output logic [CNT_W-1:0] cnt,
    output logic             err
);

    localparam logic signed [CNT_W+2:0] MAX_S = (CNT_W+3)'((1 << CNT_W) - 1);

    logic signed [CNT_W+2:0] sum;
    logic                    under;
    logic                    over;

    // Signed next value, wide enough to see both overflow and underflow
    always_comb begin
        sum   = $signed({3'b000, cnt})
              + $signed({{(CNT_W+1){1'b0}}, inc})
              - $signed({{(CNT_W+1){1'b0}}, dec});
        under = sum[CNT_W+2];
        over  = !under && (sum > MAX_S);
    end

    // Counter saturates at max, clamps at zero; error is sticky until reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            err <= 1'b0;
        end else begin
            if (over) begin
                cnt <= '1;
            end else if (under) begin
                cnt <= '0;
            end else begin
                cnt <= sum[CNT_W-1:0];
            end
            err <= err | over | under;
        end
    end

endmodule

// File: rtl/pipe_regfile.sv
// rtl/pipe_regfile.sv - two-read/two-write register file with bypass and pending-write scoreboard
module pipe_regfile #(
    parameter int                DATA_W = y86_pkg::DATA_W,
    parameter int                NREGS  = y86_pkg::NREGS,
    parameter int                ADDR_W = y86_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] RNONE  = y86_pkg::RNONE,
    parameter int                SP_IDX = y86_pkg::SP_IDX,
    parameter int                CNT_W  = y86_pkg::CNT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_W-1:0]       srcA,
    input  logic [ADDR_W-1:0]       srcB,
    output logic [DATA_W-1:0]       valA,
    output logic [DATA_W-1:0]       valB,
    output logic                    busyA,
    output logic                    busyB,
    input  logic                    iss_en,
    input  logic [ADDR_W-1:0]       iss_dstE,
    input  logic [ADDR_W-1:0]       iss_dstM,
    input  logic                    wb_en,
    input  logic [ADDR_W-1:0]       dstE,
    input  logic [ADDR_W-1:0]       dstM,
    input  logic [DATA_W-1:0]       valE,
    input  logic [DATA_W-1:0]       valM,
    output logic                    sb_err,
    output logic [DATA_W*NREGS-1:0] reg_flat
);

    // The stack pointer must be a real register and RNONE must sit outside the array
    if (NREGS < 1 || NREGS > 32'(RNONE) || SP_IDX < 0 || SP_IDX >= NREGS) begin : g_bad_params
        $error("pipe_regfile: inconsistent NREGS/RNONE/SP_IDX");
    end

    logic [DATA_W-1:0] regs      [NREGS];
    logic [DATA_W-1:0] regs_next [NREGS];
    logic [1:0]        inc       [NREGS];
    logic [1:0]        dec       [NREGS];
    logic [CNT_W-1:0]  cnt       [NREGS];
    logic [NREGS-1:0]  cnt_err;
    logic              we_e, we_m, is_e, is_m;

    function automatic logic idx_ok(input logic [ADDR_W-1:0] idx);
        return (idx != RNONE) && (32'(idx) < NREGS);
    endfunction

    // Port qualifiers: out-of-range and RNONE indices neither write nor count
    always_comb begin
        we_e = wb_en && idx_ok(dstE);
        we_m = wb_en && idx_ok(dstM);
        is_e = iss_en && idx_ok(iss_dstE);
        is_m = iss_en && idx_ok(iss_dstM);
    end

    // Next array state; M is applied last so it wins when both ports hit one register
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            regs_next[i] = regs[i];
            if (we_e && dstE == ADDR_W'(i)) regs_next[i] = valE;
            if (we_m && dstM == ADDR_W'(i)) regs_next[i] = valM;
        end
    end

    // Storage array; reset leaves register i holding its own index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= DATA_W'(i);
        end else begin
            for (int i = 0; i < NREGS; i++) regs[i] <= regs_next[i];
        end
    end

    // The array is the registered snapshot; expose it flattened
    always_comb begin
        for (int i = 0; i < NREGS; i++) reg_flat[i*DATA_W +: DATA_W] = regs[i];
    end

    // Per-register issue/retire counts, each 0..2
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            inc[i] = {1'b0, is_e && iss_dstE == ADDR_W'(i)} + {1'b0, is_m && iss_dstM == ADDR_W'(i)};
            dec[i] = {1'b0, we_e && dstE == ADDR_W'(i)} + {1'b0, we_m && dstM == ADDR_W'(i)};
        end
    end

    for (genvar g = 0; g < NREGS; g++) begin : g_cnt
        pipe_sb_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk (clk),
            .rst (rst),
            .inc (inc[g]),
            .dec (dec[g]),
            .cnt (cnt[g]),
            .err (cnt_err[g])
        );
    end

    assign sb_err = |cnt_err;

    // Read port A: array, then E bypass, then M bypass; busy counts writes left after this retire
    always_comb begin
        valA  = '0;
        busyA = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            if (srcA == ADDR_W'(i)) begin
                valA  = regs[i];
                busyA = {2'b00, cnt[i]} > {{CNT_W{1'b0}}, dec[i]};
            end
        end
        if (we_e && dstE == srcA) valA = valE;
        if (we_m && dstM == srcA) valA = valM;
    end

    // Read port B: same priority as port A
    always_comb begin
        valB  = '0;
        busyB = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            if (srcB == ADDR_W'(i)) begin
                valB  = regs[i];
                busyB = {2'b00, cnt[i]} > {{CNT_W{1'b0}}, dec[i]};
            end
        end
        if (we_e && dstE == srcB) valB = valE;
        if (we_m && dstM == srcB) valB = valM;
    end

endmodule

// File: tb/tb_pipe_regfile.sv
// tb/tb_pipe_regfile.sv - directed self-checking bench for pipe_regfile
module tb_pipe_regfile;

    localparam int DW = 64;
    localparam int NR = 15;

    logic            clk = 1'b0;
    logic            rst;
    logic [3:0]      srcA, srcB;
    logic [DW-1:0]   valA, valB;
    logic            busyA, busyB;
    logic            iss_en;
    logic [3:0]      iss_dstE, iss_dstM;
    logic            wb_en;
    logic [3:0]      dstE, dstM;
    logic [DW-1:0]   valE, valM;
    logic            sb_err;
    logic [DW*NR-1:0] reg_flat;

    int n_checks = 0;
    int n_fails  = 0;
    logic [DW-1:0] model [NR];

    pipe_regfile dut (
        .clk      (clk),
        .rst      (rst),
        .srcA     (srcA),
        .srcB     (srcB),
        .valA     (valA),
        .valB     (valB),
        .busyA    (busyA),
        .busyB    (busyB),
        .iss_en   (iss_en),
        .iss_dstE (iss_dstE),
        .iss_dstM (iss_dstM),
        .wb_en    (wb_en),
        .dstE     (dstE),
        .dstM     (dstM),
        .valE     (valE),
        .valM     (valM),
        .sb_err   (sb_err),
        .reg_flat (reg_flat)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic idle();
        iss_en = 1'b0; iss_dstE = 4'hF; iss_dstM = 4'hF;
        wb_en  = 1'b0; dstE = 4'hF; dstM = 4'hF;
        valE   = '0;   valM = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) model[i] = 64'(i);
    endtask

    task automatic test_reset();
        idle();
        srcA = 4'd5; srcB = 4'hF;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        model_reset();
        #1;
        n_checks++; if (reg_flat[3*DW +: DW] !== 64'd3) begin n_fails++; $display("FAIL reset_reg3 got %0h want 3", reg_flat[3*DW +: DW]); end
        n_checks++; if (reg_flat[14*DW +: DW] !== 64'd14) begin n_fails++; $display("FAIL reset_reg14 got %0h want e", reg_flat[14*DW +: DW]); end
        for (int i = 0; i < NR; i++) begin
            n_checks++; if (reg_flat[i*DW +: DW] !== model[i]) begin n_fails++; $display("FAIL reset_flat[%0d] got %0h want %0h", i, reg_flat[i*DW +: DW], model[i]); end
        end
        n_checks++; if (valA !== 64'd5) begin n_fails++; $display("FAIL reset_valA got %0h want 5", valA); end
        n_checks++; if (valB !== 64'd0) begin n_fails++; $display("FAIL reset_valB_rnone got %0h want 0", valB); end
        n_checks++; if (busyA !== 1'b0) begin n_fails++; $display("FAIL reset_busyA got %b want 0", busyA); end
        n_checks++; if (sb_err !== 1'b0) begin n_fails++; $display("FAIL reset_sb_err got %b want 0", sb_err); end
    endtask

    task automatic test_bypass_e();
        iss_en = 1'b1; iss_dstE = 4'd2;
        tick();
        idle();
        wb_en = 1'b1; dstE = 4'd2; valE = 64'hDEAD;
        srcA = 4'd2; srcB = 4'd3;
        #1;
        n_checks++; if (valA !== 64'hDEAD) begin n_fails++; $display("FAIL bypass_e_valA got %0h want dead", valA); end
        n_checks++; if (valB !== 64'd3) begin n_fails++; $display("FAIL bypass_e_valB got %0h want 3", valB); end
        n_checks++; if (busyA !== 1'b0) begin n_fails++; $display("FAIL bypass_e_busyA got %b want 0", busyA); end
        tick();
        idle();
        model[2] = 64'hDEAD;
        #1;
        n_checks++; if (reg_flat[2*DW +: DW] !== model[2]) begin n_fails++; $display("FAIL bypass_e_reg2 got %0h want %0h", reg_flat[2*DW +: DW], model[2]); end
        n_checks++; if (valA !== 64'hDEAD) begin n_fails++; $display("FAIL bypass_e_valA_after got %0h want dead", valA); end
        n_checks++; if (sb_err !== 1'b0) begin n_fails++; $display("FAIL bypass_e_sb_err got %b want 0", sb_err); end
    endtask

    task automatic test_m_priority();
        srcB = 4'd4;
        iss_en = 1'b1; iss_dstE = 4'd4; iss_dstM = 4'd4;
        #1;
        n_checks++; if (busyB !== 1'b0) begin n_fails++; $display("FAIL mprio_busy_same_cycle got %b want 0", busyB); end
        tick();
        idle();
        #1;
        n_checks++; if (busyB !== 1'b1) begin n_fails++; $display("FAIL mprio_busy_pending got %b want 1", busyB); end
        wb_en = 1'b1; dstE = 4'd4; dstM = 4'd4; valE = 64'h100; valM = 64'h200;
        #1;
        n_checks++; if (valB !== 64'h200) begin n_fails++; $display("FAIL mprio_valB got %0h want 200", valB); end
        n_checks++; if (busyB !== 1'b0) begin n_fails++; $display("FAIL mprio_busy_retire got %b want 0", busyB); end
        tick();
        idle();
        model[4] = 64'h200;
        #1;
        n_checks++; if (reg_flat[4*DW +: DW] !== model[4]) begin n_fails++; $display("FAIL mprio_reg4 got %0h want %0h", reg_flat[4*DW +: DW], model[4]); end
        n_checks++; if (sb_err !== 1'b0) begin n_fails++; $display("FAIL mprio_sb_err got %b want 0", sb_err); end
    endtask

    task automatic test_busy();
        srcA = 4'd6;
        iss_en = 1'b1; iss_dstE = 4'd6;
        #1;
        n_checks++; if (busyA !== 1'b0) begin n_fails++; $display("FAIL busy_first_issue got %b want 0", busyA); end
        tick();
        n_checks++; if (busyA !== 1'b1) begin n_fails++; $display("FAIL busy_second_issue got %b want 1", busyA); end
        tick();
        idle();
        wb_en = 1'b1; dstE = 4'd6; valE = 64'h66;
        #1;
        n_checks++; if (busyA !== 1'b1) begin n_fails++; $display("FAIL busy_first_retire got %b want 1", busyA); end
        n_checks++; if (valA !== 64'h66) begin n_fails++; $display("FAIL busy_first_retire_valA got %0h want 66", valA); end
        tick();
        valE = 64'h67;
        #1;
        n_checks++; if (busyA !== 1'b0) begin n_fails++; $display("FAIL busy_second_retire got %b want 0", busyA); end
        n_checks++; if (valA !== 64'h67) begin n_fails++; $display("FAIL busy_second_retire_valA got %0h want 67", valA); end
        tick();
        idle();
        model[6] = 64'h67;
        #1;
        n_checks++; if (busyA !== 1'b0) begin n_fails++; $display("FAIL busy_idle got %b want 0", busyA); end
        n_checks++; if (reg_flat[6*DW +: DW] !== model[6]) begin n_fails++; $display("FAIL busy_reg6 got %0h want %0h", reg_flat[6*DW +: DW], model[6]); end
        n_checks++; if (sb_err !== 1'b0) begin n_fails++; $display("FAIL busy_sb_err got %b want 0", sb_err); end
    endtask

    task automatic test_rnone();
        srcA = 4'hF; srcB = 4'd4;
        wb_en = 1'b1; dstE = 4'hF; dstM = 4'hF; valE = 64'h1111; valM = 64'h2222;
        #1;
        n_checks++; if (valA !== 64'd0) begin n_fails++; $display("FAIL rnone_valA got %0h want 0", valA); end
        n_checks++; if (busyA !== 1'b0) begin n_fails++; $display("FAIL rnone_busyA got %b want 0", busyA); end
        tick();
        idle();
        #1;
        for (int i = 0; i < NR; i++) begin
            n_checks++; if (reg_flat[i*DW +: DW] !== model[i]) begin n_fails++; $display("FAIL rnone_flat[%0d] got %0h want %0h", i, reg_flat[i*DW +: DW], model[i]); end
        end
        n_checks++; if (busyB !== 1'b0) begin n_fails++; $display("FAIL rnone_busyB got %b want 0", busyB); end
        n_checks++; if (sb_err !== 1'b0) begin n_fails++; $display("FAIL rnone_sb_err got %b want 0", sb_err); end
    endtask

    task automatic test_saturate();
        srcA = 4'd7;
        iss_en = 1'b1; iss_dstE = 4'd7;
        tick(); tick(); tick();
        n_checks++; if (sb_err !== 1'b0) begin n_fails++; $display("FAIL sat_no_err_at_max got %b want 0", sb_err); end
        tick();
        idle();
        #1;
        n_checks++; if (sb_err !== 1'b1) begin n_fails++; $display("FAIL sat_err got %b want 1", sb_err); end
        n_checks++; if (busyA !== 1'b1) begin n_fails++; $display("FAIL sat_busy got %b want 1", busyA); end
        wb_en = 1'b1; dstE = 4'd7; dstM = 4'd7; valE = 64'h70; valM = 64'h77;
        #1;
        n_checks++; if (busyA !== 1'b1) begin n_fails++; $display("FAIL sat_busy_after_dec2 got %b want 1", busyA); end
        n_checks++; if (valA !== 64'h77) begin n_fails++; $display("FAIL sat_valA got %0h want 77", valA); end
        tick();
        idle();
        model[7] = 64'h77;
        #1;
        n_checks++; if (reg_flat[7*DW +: DW] !== model[7]) begin n_fails++; $display("FAIL sat_reg7 got %0h want %0h", reg_flat[7*DW +: DW], model[7]); end
        n_checks++; if (sb_err !== 1'b1) begin n_fails++; $display("FAIL sat_err_sticky got %b want 1", sb_err); end
        iss_en = 1'b1; iss_dstE = 4'd7;
        wb_en = 1'b1; dstE = 4'd7; valE = 64'h99;
        #1;
        rst = 1'b1;
        #1;
        n_checks++; if (sb_err !== 1'b0) begin n_fails++; $display("FAIL sat_async_rst_err got %b want 0", sb_err); end
        n_checks++; if (reg_flat[7*DW +: DW] !== 64'd7) begin n_fails++; $display("FAIL sat_async_rst_reg7 got %0h want 7", reg_flat[7*DW +: DW]); end
        tick();
        rst = 1'b0;
        idle();
        model_reset();
        #1;
        n_checks++; if (reg_flat[7*DW +: DW] !== model[7]) begin n_fails++; $display("FAIL sat_post_rst_reg7 got %0h want %0h", reg_flat[7*DW +: DW], model[7]); end
        n_checks++; if (busyA !== 1'b0) begin n_fails++; $display("FAIL sat_post_rst_busy got %b want 0", busyA); end
        n_checks++; if (sb_err !== 1'b0) begin n_fails++; $display("FAIL sat_post_rst_err got %b want 0", sb_err); end
    endtask

    task automatic test_underflow();
        srcA = 4'd7;
        wb_en = 1'b1; dstE = 4'd7; valE = 64'h5;
        #1;
        n_checks++; if (busyA !== 1'b0) begin n_fails++; $display("FAIL under_busy got %b want 0", busyA); end
        tick();
        idle();
        model[7] = 64'h5;
        #1;
        n_checks++; if (sb_err !== 1'b1) begin n_fails++; $display("FAIL under_err got %b want 1", sb_err); end
        n_checks++; if (reg_flat[7*DW +: DW] !== model[7]) begin n_fails++; $display("FAIL under_reg7 got %0h want %0h", reg_flat[7*DW +: DW], model[7]); end
        n_checks++; if (busyA !== 1'b0) begin n_fails++; $display("FAIL under_busy_clamped got %b want 0", busyA); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        #1;
        n_checks++; if (sb_err !== 1'b0) begin n_fails++; $display("FAIL under_rst_err got %b want 0", sb_err); end
        n_checks++; if (reg_flat[7*DW +: DW] !== model[7]) begin n_fails++; $display("FAIL under_rst_reg7 got %0h want %0h", reg_flat[7*DW +: DW], model[7]); end
    endtask

    initial begin
        test_reset();
        test_bypass_e();
        test_m_priority();
        test_busy();
        test_rnone();
        test_saturate();
        test_underflow();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
